// File: rtl/packet_sender_if.sv
// packet_sender_if: host payload/command handshake and receiver-facing packet stream.
interface packet_sender_if #(parameter int DATA_W = 8);
   logic              payload_valid;
   logic [DATA_W-1:0] payload_data;
   logic              payload_ready;
   logic              cmd_valid;
   logic [1:0]        cmd_dest;
   logic [5:0]        cmd_len;
   logic              cmd_ready;
   logic              cmd_err;
   logic              stop_packet_send;
   logic              packet_valid_o;
   logic [DATA_W-1:0] pdata;
   logic              busy;
   modport master (
      input  payload_valid, payload_data, cmd_valid, cmd_dest, cmd_len, stop_packet_send,
      output payload_ready, cmd_ready, cmd_err, packet_valid_o, pdata, busy
   );
   modport slave (
      output payload_valid, payload_data, cmd_valid, cmd_dest, cmd_len, stop_packet_send,
      input  payload_ready, cmd_ready, cmd_err, packet_valid_o, pdata, busy
   );
endinterface

// File: rtl/packet_sender.sv
// packet_sender: buffers payload bytes and frames them as header, payload, parity.
// Optional PKT_SENDER_STATS_EN adds saturating pkt_count/stall_count outputs.
module packet_sender #(
   parameter int DATA_W     = 8,
   parameter int BUF_DEPTH  = 64,
   parameter int GAP_CYCLES = 1
) (
   input logic            clk1,
   input logic            rst,
   packet_sender_if.master bus
`ifdef PKT_SENDER_STATS_EN
   ,
   output logic [15:0]    pkt_count,
   output logic [15:0]    stall_count
`endif
);
   localparam int PW = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
   localparam int CW = $clog2(BUF_DEPTH + 1);
   typedef enum logic [2:0] {IDLE, HEADER, PAYLOAD, PARITY, GAP} state_t;
   state_t            state;
   logic [DATA_W-1:0] mem [BUF_DEPTH];
   logic [PW-1:0]     wr_ptr, rd_ptr;
   logic [CW-1:0]     count;
   logic [5:0]        len, cnt;
   logic [3:0]        gap;
   logic [DATA_W-1:0] parity, pdata, head, hdr;
   logic              valid, cmd_err;
   logic              wr, rd, xfer, legal, accept, illegal_cmd;
   function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
      return (p == PW'(BUF_DEPTH - 1)) ? '0 : p + 1'b1;
   endfunction
   assign head              = mem[rd_ptr];
   assign hdr               = DATA_W'({bus.cmd_len, bus.cmd_dest});
   assign xfer              = valid && !bus.stop_packet_send;
   assign legal             = (bus.cmd_dest != 2'b11) && (bus.cmd_len != 6'd0);
   assign bus.payload_ready = rst && (count < CW'(BUF_DEPTH));
   assign bus.cmd_ready     = rst && (state == IDLE) && (count >= CW'(bus.cmd_len));
   assign accept            = bus.cmd_valid && bus.cmd_ready && legal;
   assign illegal_cmd       = (state == IDLE) && bus.cmd_valid && !legal;
   assign wr                = bus.payload_valid && bus.payload_ready;
   // The last payload transfer places parity, so it does not pop the buffer.
   assign rd                = xfer && ((state == HEADER) || ((state == PAYLOAD) && (cnt != 6'd1)));
   assign bus.packet_valid_o = valid;
   assign bus.pdata         = pdata;
   assign bus.cmd_err       = cmd_err;
   assign bus.busy          = (state != IDLE);
   always_ff @(posedge clk1) begin
      if (wr) mem[wr_ptr] <= bus.payload_data;
   end
   always_ff @(posedge clk1 or negedge rst) begin
      if (!rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (wr) wr_ptr <= nxt(wr_ptr);
         if (rd) rd_ptr <= nxt(rd_ptr);
         count <= (wr && !rd) ? count + 1'b1 : (!wr && rd) ? count - 1'b1 : count;
      end
   end
   always_ff @(posedge clk1 or negedge rst) begin
      if (!rst) begin
         state   <= IDLE;
         valid   <= 1'b0;
         pdata   <= '0;
         parity  <= '0;
         cmd_err <= 1'b0;
         len     <= '0;
         cnt     <= '0;
         gap     <= '0;
      end else begin
         cmd_err <= illegal_cmd;
         case (state)
            IDLE: if (accept) begin
               pdata  <= hdr;
               parity <= hdr;
               len    <= bus.cmd_len;
               valid  <= 1'b1;
               state  <= HEADER;
            end
            HEADER: if (xfer) begin
               pdata  <= head;
               parity <= parity ^ head;
               cnt    <= len;
               state  <= PAYLOAD;
            end
            PAYLOAD: if (xfer) begin
               cnt <= cnt - 1'b1;
               if (cnt != 6'd1) begin
                  pdata  <= head;
                  parity <= parity ^ head;
               end else begin
                  pdata <= parity;
                  state <= PARITY;
               end
            end
            PARITY: if (xfer) begin
               valid <= 1'b0;
               pdata <= '0;
               gap   <= 4'(GAP_CYCLES - 1);
               state <= GAP;
            end
            GAP: if (gap == 4'd0) state <= IDLE; else gap <= gap - 1'b1;
            default: state <= IDLE;
         endcase
      end
   end
`ifdef PKT_SENDER_STATS_EN
   always_ff @(posedge clk1 or negedge rst) begin
      if (!rst) begin
         pkt_count   <= '0;
         stall_count <= '0;
      end else begin
         if (state == PARITY && xfer && pkt_count != 16'hFFFF) pkt_count <= pkt_count + 1'b1;
         if (valid && bus.stop_packet_send && stall_count != 16'hFFFF) stall_count <= stall_count + 1'b1;
      end
   end
`endif
endmodule

// File: tb/tb_packet_sender.sv
// tb_packet_sender: directed vector table plus hand-written multi-cycle sequences.
module tb_packet_sender;
   logic clk1 = 1'b0;
   logic rst  = 1'b0;
   always #5 clk1 = ~clk1;
   packet_sender_if #(.DATA_W(8)) bus();
`ifdef PKT_SENDER_STATS_EN
   logic [15:0] pkt_count, stall_count;
`endif
   packet_sender #(.DATA_W(8), .BUF_DEPTH(64), .GAP_CYCLES(1)) dut (
      .clk1(clk1),
      .rst(rst),
      .bus(bus)
`ifdef PKT_SENDER_STATS_EN
      , .pkt_count(pkt_count), .stall_count(stall_count)
`endif
   );
   typedef struct {
      logic       pv;
      logic [7:0] pd;
      logic       cv;
      logic [1:0] dest;
      logic [5:0] len;
      logic       stop;
      logic       valid;
      logic [7:0] pdata;
      logic       busy;
      logic       cready;
      logic       err;
      logic [6:0] cnt;
   } vec_t;
   vec_t       vecs[$];
   logic [7:0] model[$];
   logic [7:0] rx[$];
   logic [7:0] exp_q[$];
   int         n_chk = 0;
   int         n_fail = 0;
   function automatic vec_t mk(logic pv, logic [7:0] pd, logic cv, logic [1:0] dest, logic [5:0] len,
                               logic stop, logic valid, logic [7:0] pdata, logic busy, logic cready,
                               logic err, logic [6:0] cnt);
      vec_t v;
      v.pv = pv; v.pd = pd; v.cv = cv; v.dest = dest; v.len = len; v.stop = stop;
      v.valid = valid; v.pdata = pdata; v.busy = busy; v.cready = cready; v.err = err; v.cnt = cnt;
      return v;
   endfunction
   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask
   task automatic mk_pkt(input logic [1:0] dest, input int len);
      logic [7:0] par, b;
      par = {len[5:0], dest};
      exp_q.delete();
      exp_q.push_back(par);
      for (int i = 0; i < len; i++) begin
         b = model.pop_front();
         exp_q.push_back(b);
         par ^= b;
      end
      exp_q.push_back(par);
   endtask
   task automatic check_pkt(input string name);
      int bad_idx;
      bad_idx = -1;
      for (int i = 0; i < exp_q.size() && i < rx.size(); i++)
         if (bad_idx < 0 && rx[i] !== exp_q[i]) bad_idx = i;
      n_chk++;
      if (rx.size() != exp_q.size() || bad_idx >= 0) begin
         n_fail++;
         if (bad_idx >= 0)
            $display("FAIL %s: byte %0d got %0h, expected %0h (len %0d vs %0d)", name, bad_idx,
                     rx[bad_idx], exp_q[bad_idx], rx.size(), exp_q.size());
         else
            $display("FAIL %s: got %0d bytes, expected %0d", name, rx.size(), exp_q.size());
      end
   endtask
   // Collects transferred bytes until packet_valid_o falls after having been seen high.
   task automatic capture();
      bit seen, done;
      seen = 0;
      done = 0;
      rx.delete();
      for (int c = 0; c < 300 && !done; c++) begin
         @(negedge clk1);
         bus.cmd_valid = 1'b0;
         #1;
         if (bus.packet_valid_o) begin
            if (!bus.stop_packet_send) rx.push_back(bus.pdata);
            seen = 1;
         end else if (seen) done = 1;
      end
      if (!done) begin
         n_chk++;
         n_fail++;
         $display("FAIL capture_timeout: got seen=%0d, expected packet end", seen);
      end
   endtask
   initial begin
      int d, bad;
      bit seen, done;
      bus.payload_valid = 0; bus.payload_data = 0; bus.cmd_valid = 0;
      bus.cmd_dest = 0; bus.cmd_len = 0; bus.stop_packet_send = 0;
      //            pv  pd     cv dest len stop  valid pdata  busy cr err cnt
      vecs.push_back(mk(1, 8'h01, 0, 0, 3, 0,  0, 8'h00, 0, 0, 0, 0));
      vecs.push_back(mk(1, 8'h02, 0, 0, 3, 0,  0, 8'h00, 0, 0, 0, 1));
      vecs.push_back(mk(1, 8'h04, 0, 0, 3, 0,  0, 8'h00, 0, 0, 0, 2));
      vecs.push_back(mk(0, 8'h00, 1, 0, 3, 0,  0, 8'h00, 0, 1, 0, 3));
      vecs.push_back(mk(0, 8'h00, 0, 0, 3, 0,  1, 8'h0C, 1, 0, 0, 3));
      vecs.push_back(mk(0, 8'h00, 0, 0, 3, 0,  1, 8'h01, 1, 0, 0, 2));
      vecs.push_back(mk(0, 8'h00, 0, 0, 3, 0,  1, 8'h02, 1, 0, 0, 1));
      vecs.push_back(mk(0, 8'h00, 0, 0, 3, 0,  1, 8'h04, 1, 0, 0, 0));
      vecs.push_back(mk(0, 8'h00, 0, 0, 3, 0,  1, 8'h0B, 1, 0, 0, 0));
      vecs.push_back(mk(0, 8'h00, 0, 0, 3, 1,  0, 8'h00, 1, 0, 0, 0));
      vecs.push_back(mk(0, 8'h00, 0, 0, 3, 1,  0, 8'h00, 0, 0, 0, 0));
      vecs.push_back(mk(1, 8'h01, 0, 0, 3, 0,  0, 8'h00, 0, 0, 0, 0));
      vecs.push_back(mk(1, 8'h02, 0, 0, 3, 0,  0, 8'h00, 0, 0, 0, 1));
      vecs.push_back(mk(1, 8'h04, 0, 0, 3, 0,  0, 8'h00, 0, 0, 0, 2));
      vecs.push_back(mk(0, 8'h00, 1, 0, 3, 0,  0, 8'h00, 0, 1, 0, 3));
      vecs.push_back(mk(0, 8'h00, 0, 0, 3, 0,  1, 8'h0C, 1, 0, 0, 3));
      vecs.push_back(mk(0, 8'h00, 0, 0, 3, 0,  1, 8'h01, 1, 0, 0, 2));
      vecs.push_back(mk(0, 8'h00, 0, 0, 3, 1,  1, 8'h02, 1, 0, 0, 1));
      vecs.push_back(mk(0, 8'h00, 0, 0, 3, 1,  1, 8'h02, 1, 0, 0, 1));
      vecs.push_back(mk(0, 8'h00, 0, 0, 3, 1,  1, 8'h02, 1, 0, 0, 1));
      vecs.push_back(mk(0, 8'h00, 0, 0, 3, 0,  1, 8'h02, 1, 0, 0, 1));
      vecs.push_back(mk(0, 8'h00, 0, 0, 3, 0,  1, 8'h04, 1, 0, 0, 0));
      vecs.push_back(mk(0, 8'h00, 0, 0, 3, 0,  1, 8'h0B, 1, 0, 0, 0));
      vecs.push_back(mk(0, 8'h00, 0, 0, 3, 1,  0, 8'h00, 1, 0, 0, 0));
      vecs.push_back(mk(0, 8'h00, 0, 0, 3, 0,  0, 8'h00, 0, 0, 0, 0));
      vecs.push_back(mk(0, 8'h00, 1, 3, 5, 0,  0, 8'h00, 0, 0, 0, 0));
      vecs.push_back(mk(0, 8'h00, 0, 3, 5, 0,  0, 8'h00, 0, 0, 1, 0));
      vecs.push_back(mk(0, 8'h00, 1, 1, 0, 0,  0, 8'h00, 0, 1, 0, 0));
      vecs.push_back(mk(0, 8'h00, 0, 1, 3, 0,  0, 8'h00, 0, 0, 1, 0));
      vecs.push_back(mk(0, 8'h00, 0, 1, 3, 1,  0, 8'h00, 0, 0, 0, 0));
      // Reset state
      @(negedge clk1); #1;
      check("reset_outputs", {bus.packet_valid_o, bus.pdata, bus.cmd_err, bus.busy, bus.payload_ready, bus.cmd_ready}, 0);
      @(negedge clk1);
      rst = 1'b1;
      // Cycle-by-cycle vectors: basic packet, stalled packet, illegal commands
      foreach (vecs[i]) begin
         @(negedge clk1);
         bus.payload_valid = vecs[i].pv; bus.payload_data = vecs[i].pd; bus.cmd_valid = vecs[i].cv;
         bus.cmd_dest = vecs[i].dest; bus.cmd_len = vecs[i].len; bus.stop_packet_send = vecs[i].stop;
         #1;
         check($sformatf("vec%0d", i),
               {bus.packet_valid_o, bus.pdata, bus.busy, bus.cmd_ready, bus.cmd_err, 7'(dut.count)},
               {vecs[i].valid, vecs[i].pdata, vecs[i].busy, vecs[i].cready, vecs[i].err, vecs[i].cnt});
      end
      // Insufficient data: command waits until enough bytes are buffered
      @(negedge clk1);
      bus.stop_packet_send = 0; bus.cmd_valid = 0; bus.payload_valid = 1; bus.payload_data = 8'hAA;
      @(negedge clk1); bus.payload_data = 8'hBB;
      @(negedge clk1); bus.payload_data = 8'hCC; bus.cmd_valid = 1; bus.cmd_dest = 1; bus.cmd_len = 4;
      #1; check("short_cready_2", bus.cmd_ready, 0);
      @(negedge clk1); bus.payload_data = 8'hDD;
      #1; check("short_cready_3", bus.cmd_ready, 0);
      @(negedge clk1); bus.payload_valid = 0;
      #1; check("short_cready_4", bus.cmd_ready, 1);
      model = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};
      mk_pkt(1, 4);
      capture();
      check_pkt("short_pkt");
      // Reset in the middle of a 10-byte packet
      model.delete();
      for (int i = 0; i < 10; i++) begin
         @(negedge clk1); bus.payload_valid = 1; bus.payload_data = 8'(i * 3 + 1);
      end
      @(negedge clk1); bus.payload_valid = 0; bus.cmd_valid = 1; bus.cmd_dest = 2; bus.cmd_len = 10;
      @(negedge clk1); bus.cmd_valid = 0;
      #1; check("rst_hdr", {bus.packet_valid_o, bus.pdata}, {1'b1, 8'h2A});
      repeat (3) @(negedge clk1);
      #2; rst = 1'b0;
      #1; check("rst_async_outputs", {bus.packet_valid_o, bus.pdata, bus.cmd_err, bus.busy, bus.payload_ready, bus.cmd_ready}, 0);
      @(negedge clk1); #1;
      check("rst_pready_held", bus.payload_ready, 0);
      @(negedge clk1); rst = 1'b1;
      #1; check("rst_count_cleared", {7'(dut.count), bus.busy}, 0);
      repeat (5) @(negedge clk1);
      #1; check("rst_no_resume", {bus.packet_valid_o, bus.busy}, 0);
      // Full buffer, then two len=63 packets with the second one wrapping the pointers
      model.delete();
      for (int i = 0; i < 64; i++) begin
         @(negedge clk1); bus.payload_valid = 1; bus.payload_data = 8'(i);
         model.push_back(8'(i));
      end
      @(negedge clk1); bus.payload_valid = 0;
      #1; check("full_pready", {bus.payload_ready, 7'(dut.count)}, {1'b0, 7'd64});
      @(negedge clk1);
      bus.cmd_valid = 1; bus.cmd_dest = 0; bus.cmd_len = 63; bus.payload_valid = 1;
      d = 64; bus.payload_data = 8'(d);
      #1; check("full_cready", bus.cmd_ready, 1);
      mk_pkt(0, 63);
      rx.delete(); seen = 0; done = 0; bad = 0;
      for (int c = 0; c < 300 && !done; c++) begin
         if (bus.payload_valid && bus.payload_ready) begin
            model.push_back(8'(d));
            d++;
         end
         if (bus.packet_valid_o) begin
            if (!bus.stop_packet_send) rx.push_back(bus.pdata);
            seen = 1;
            if (rx.size() >= 2 && rx.size() <= 64 && dut.count != 63) bad++;
         end else if (seen) done = 1;
         @(negedge clk1);
         bus.cmd_valid = 0; bus.payload_data = 8'(d);
         #1;
      end
      bus.payload_valid = 0;
      check("wrap1_done", done, 1);
      check_pkt("wrap1_pkt");
      check("wrap1_count_steady", bad, 0);
      done = 0;
      for (int c = 0; c < 20 && !done; c++) begin
         @(negedge clk1); #1;
         if (!bus.busy) done = 1;
      end
      check("wrap1_idle", {done, 7'(dut.count)}, {1'b1, 7'd64});
      @(negedge clk1); bus.cmd_valid = 1; bus.cmd_dest = 0; bus.cmd_len = 63;
      mk_pkt(0, 63);
      capture();
      check_pkt("wrap2_pkt");
`ifdef PKT_SENDER_STATS_EN
      check("stats", {pkt_count, stall_count}, {16'd2, 16'd0});
`endif
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, expected end of test");
      $fatal(1, "watchdog");
   end
endmodule

// File: doc/packet_sender.md
Name: packet_sender

Overview:
- Upstream stage of the packet receiver in the custom router; sits in the clk1 domain.
- Buffers host payload bytes and, on command, frames them as header, payload and parity bytes.
- Streams the frame on packet_valid_o/pdata and honours stop_packet_send backpressure.
- Its outputs connect directly to the receiver's packet_valid_i and pdata inputs.

Parameters:
- DATA_W, 8, byte width of payload and pdata.
- BUF_DEPTH, 64, payload buffer entries; must be at least 63 (max packet length).
- GAP_CYCLES, 1, minimum idle cycles with packet_valid_o low between packets (1..15).

Ports:
- clk1  in  1  system clock; all logic on rising edge.
- rst  in  1  asynchronous active-low reset.
- payload_valid  in  1  host offers a payload byte.
- payload_data  in  DATA_W  payload byte.
- payload_ready  out  1  buffer can accept a byte.
- cmd_valid  in  1  host requests packet transmission.
- cmd_dest  in  2  destination: 00 = port1, 01 = port2, 10 = port3, 11 = illegal.
- cmd_len  in  6  payload length in bytes, 1..63.
- cmd_ready  out  1  command accepted this cycle when cmd_valid is also high.
- cmd_err  out  1  one-cycle pulse when an illegal command is dropped.
- stop_packet_send  in  1  receiver backpressure.
- packet_valid_o  out  1  drives receiver packet_valid_i.
- pdata  out  DATA_W  drives receiver pdata.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset:
  - rst low asynchronously forces state IDLE, clears the buffer (pointers and count = 0) and all counters.
  - Reset values: packet_valid_o=0, pdata=0, cmd_err=0, busy=0, payload_ready=0, cmd_ready=0.
  - Reset mid-packet aborts the packet; no resume after reset release.
- Payload buffer:
  - Synchronous FIFO of BUF_DEPTH entries; payload_ready = (count < BUF_DEPTH).
  - A write occurs on an edge where payload_valid && payload_ready.
  - Simultaneous write and read leave count unchanged; pointers wrap modulo BUF_DEPTH.
- Commands:
  - cmd_ready = (state==IDLE) && (count >= cmd_len).
  - An illegal command (cmd_dest==11 or cmd_len==0) in IDLE is consumed with cmd_err pulsed for one cycle; no bytes are sent and the buffer is untouched.
- Transfer rule: a byte moves on an edge where packet_valid_o && !stop_packet_send. While stalled, pdata and packet_valid_o hold stable.
- FSM states and transitions:
  - IDLE: legal command accepted at edge N. The registered header {cmd_len, cmd_dest} appears on pdata with packet_valid_o=1 from cycle N+1, giving 1 cycle latency. The parity register is loaded with the header byte.
  - HEADER: on transfer, pop the buffer head onto pdata, XOR it into parity, load the length counter, go to PAYLOAD.
  - PAYLOAD: on each transfer, decrement the counter. If bytes remain, pop the next byte onto pdata and XOR it into parity. After the last payload transfer, place parity on pdata and go to PARITY.
  - PARITY: on transfer, drop packet_valid_o, load the gap counter and go to GAP.
  - GAP: packet_valid_o=0 for GAP_CYCLES cycles, then IDLE.
- The buffer is never read beyond cmd_len, so underrun is impossible. Extra buffered bytes remain for the next command.
- stop_packet_send asserted in IDLE or GAP has no effect.
- stop_packet_send in HEADER stalls the header (the receiver may not yet have allocated an output port).
- busy = (state != IDLE).
- Arithmetic: parity is the bitwise XOR over the header and all payload bytes. The length counter is 6 bits and never wraps, since a length of 0 is rejected.

Optional Feature:
- Macro PKT_SENDER_STATS_EN.
- Defined: adds output ports pkt_count[15:0] and stall_count[15:0].
  - pkt_count increments on each parity-byte transfer.
  - stall_count increments on each cycle with packet_valid_o && stop_packet_send.
  - Both saturate at 16'hFFFF and clear on reset.
- Undefined: these ports and counters are absent; all other behaviour is identical.

Test Plan:
- Basic packet: write 3 bytes (01, 02, 04) then cmd dest=00, len=3, with no stall.
  - pdata sequence 0x0C, 01, 02, 04, parity 0x0B, with packet_valid_o high for exactly 5 consecutive cycles.
  - packet_valid_o then low for GAP_CYCLES cycles before busy falls.
- Backpressure: same packet with stop_packet_send high for 3 cycles during payload byte 02.
  - pdata holds 02 and packet_valid_o stays 1 for those cycles; the sequence and parity are unchanged.
- Insufficient data: 2 bytes buffered, cmd len=4.
  - cmd_ready stays 0; after 2 more writes the command is accepted the next cycle.
- Illegal commands: cmd dest=11 len=5, then dest=01 len=0.
  - Each gives a single-cycle cmd_err pulse, no packet_valid_o, and buffer count unchanged.
- Reset mid-packet: assert rst during PAYLOAD of a 10-byte packet.
  - All outputs are 0 immediately, payload_ready is 0 during reset, and count is 0 after release.
- Full buffer plus wrap: write 64 bytes, then payload_ready=0.
  - Send len=63; simultaneous writes keep count constant.
  - A second len=63 packet after pointer wrap delivers the bytes in correct order.
